// File: rtl/qcl_strobe_burst_gen.sv
// Turns a (lane offset, byte length) request into one lane-strobe mask per beat,
// with valid/ready on both sides and a selectable lane-to-bit order.
module qcl_strobe_burst_gen #(
   parameter int width_p     = 8,
   parameter int len_width_p = 12,
   parameter bit lo_to_hi_p  = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       reset_n_i,
   input  logic                       v_i,
   output logic                       ready_o,
   input  logic [$clog2(width_p)-1:0] offset_i,
   input  logic [len_width_p-1:0]     len_i,
   output logic                       v_o,
   input  logic                       ready_i,
   output logic [width_p-1:0]         mask_o,
   output logic                       first_o,
   output logic                       last_o,
   output logic                       state_o
);

   localparam int cnt_w_lp = len_width_p + 1;
   localparam logic [cnt_w_lp-1:0] width_lp = cnt_w_lp'(width_p);

   // Handshake: a request moves when v_i & ready_o, a beat moves when v_o & ready_i;
   // an offered beat keeps mask_o/first_o/last_o stable until it moves.
   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } state_e;

   state_e              state_r;
   logic [cnt_w_lp-1:0] rem_r;
   logic                accept;
   logic                load;
   logic [cnt_w_lp-1:0] end_w;
   logic [cnt_w_lp-1:0] rem_next;
   logic [width_p-1:0]  first_mask;
   logic [width_p-1:0]  next_mask;

   // Thermometer code: lanes [0, n-1] set, saturating at all ones for n >= width_p.
   function automatic logic [width_p-1:0] therm(input logic [cnt_w_lp-1:0] n);
      logic [width_p-1:0] t;
      t = '0;
      for (int k = 0; k < width_p; k++) begin
         t[k] = (cnt_w_lp'(k) < n);
      end
      return t;
   endfunction

   function automatic logic [width_p-1:0] lane_map(input logic [width_p-1:0] m);
      logic [width_p-1:0] r;
      r = '0;
      for (int k = 0; k < width_p; k++) begin
         r[k] = lo_to_hi_p ? m[k] : m[width_p-1-k];
      end
      return r;
   endfunction

   assign ready_o    = (state_r == IDLE) | (ready_i & last_o);
   assign accept     = v_i & ready_o;
   assign load       = accept & (len_i != '0);
   assign end_w      = cnt_w_lp'(offset_i) + cnt_w_lp'(len_i);
   assign first_mask = therm(end_w) & ~therm(cnt_w_lp'(offset_i));
   // rem_r counts lanes from lane 0 of the current beat up to the end of the burst.
   assign rem_next   = rem_r - width_lp;
   assign next_mask  = therm(rem_next);
   assign state_o    = (state_r == BURST);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_r <= IDLE;
         rem_r   <= '0;
         v_o     <= 1'b0;
         mask_o  <= '0;
         first_o <= 1'b0;
         last_o  <= 1'b0;
      end else if (load) begin
         state_r <= BURST;
         rem_r   <= end_w;
         v_o     <= 1'b1;
         mask_o  <= lane_map(first_mask);
         first_o <= 1'b1;
         last_o  <= (end_w <= width_lp);
      end else if ((state_r == BURST) && ready_i) begin
         if (last_o) begin
            state_r <= IDLE;
            rem_r   <= '0;
            v_o     <= 1'b0;
            mask_o  <= '0;
            first_o <= 1'b0;
            last_o  <= 1'b0;
         end else begin
            rem_r   <= rem_next;
            mask_o  <= lane_map(next_mask);
            first_o <= 1'b0;
            last_o  <= (rem_next <= width_lp);
         end
      end
   end

   a_width_pow2: assert property (@(posedge clk_i)
      (width_p >= 2) && ((width_p & (width_p - 1)) == 0));

   a_no_x_ctrl: assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !$isunknown({v_i, ready_i}));

endmodule

// File: tb/tb_qcl_strobe_burst_gen.sv
// Bench for qcl_strobe_burst_gen: table vectors, hand-written corner sequences and
// random traffic, checked against a lane-arithmetic beat model.
module tb_qcl_strobe_burst_gen;

   localparam int W  = 8;
   localparam int LW = 12;
   localparam int OW = $clog2(W);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          v_i = 1'b0;
   logic          ready_i = 1'b0;
   logic [OW-1:0] offset_i = '0;
   logic [LW-1:0] len_i = '0;

   logic          ready_o, v_o, first_o, last_o, state_o;
   logic [W-1:0]  mask_o;
   logic          ready_o_r, v_o_r, first_r, last_r, state_r;
   logic [W-1:0]  mask_r;

   qcl_strobe_burst_gen #(.width_p(W), .len_width_p(LW), .lo_to_hi_p(1'b1)) dut (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(ready_o),
      .offset_i(offset_i), .len_i(len_i), .v_o(v_o), .ready_i(ready_i),
      .mask_o(mask_o), .first_o(first_o), .last_o(last_o), .state_o(state_o)
   );

   qcl_strobe_burst_gen #(.width_p(W), .len_width_p(LW), .lo_to_hi_p(1'b0)) dut_rev (
      .clk_i(clk), .reset_n_i(reset_n), .v_i(v_i), .ready_o(ready_o_r),
      .offset_i(offset_i), .len_i(len_i), .v_o(v_o_r), .ready_i(ready_i),
      .mask_o(mask_r), .first_o(first_r), .last_o(last_r), .state_o(state_r)
   );

   // clock / reset
   always #5 clk = ~clk;
   initial reset_n = 1'b0;

   int checks   = 0;
   int failures = 0;

   // scoreboard: {first, last, mask} per expected beat, in order
   logic [W+1:0] exp_q[$];
   bit           mon_en = 1'b0;
   int           mon_n;
   bit           exp_rdy;
   logic [W+1:0] mon_e;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic logic [W-1:0] rev(input logic [W-1:0] m);
      logic [W-1:0] r;
      for (int k = 0; k < W; k++) r[k] = m[W-1-k];
      return r;
   endfunction

   // Reference model: a lane is strobed iff its absolute position lies in [off, off+len).
   function automatic void model_push(input int off, input int len);
      int e;
      int nb;
      logic [W-1:0] m;
      e  = off + len;
      nb = (e + W - 1) / W;
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < W; k++) m[k] = ((b * W + k) >= off) && ((b * W + k) < e);
         exp_q.push_back({(b == 0), (b == nb - 1), m});
      end
   endfunction

   always @(negedge reset_n) exp_q.delete();

   always @(negedge clk) begin
      if (mon_en && reset_n) begin
         mon_n = exp_q.size();
         chk("mon_v_o", 32'(v_o), 32'(mon_n != 0));
         chk("mon_v_o_rev", 32'(v_o_r), 32'(mon_n != 0));
         exp_rdy = (mon_n == 0) || (ready_i && (mon_n == 1));
         chk("mon_ready_o", 32'(ready_o), 32'(exp_rdy));
         if (v_o && ready_i && (mon_n != 0)) begin
            mon_e = exp_q.pop_front();
            chk("mon_beat", 32'({first_o, last_o, mask_o}), 32'(mon_e));
            chk("mon_beat_rev", 32'({first_r, last_r, mask_r}),
                32'({mon_e[W+1:W], rev(mon_e[W-1:0])}));
         end
         if (v_i && exp_rdy && (len_i != '0)) model_push(int'(offset_i), int'(len_i));
      end
   end

   typedef struct {
      int           off;
      int           len;
      int           nb;
      logic [W-1:0] m_first;
      logic [W-1:0] m_mid;
      logic [W-1:0] m_last;
   } vec_t;

   vec_t vecs[10];

   // driver tasks
   task automatic send_req(input int off, input int len);
      v_i      = 1'b1;
      offset_i = OW'(off);
      len_i    = LW'(len);
   endtask

   task automatic apply_vec(input vec_t v);
      int got;
      logic [W-1:0] em;
      got = 0;
      @(posedge clk); #1;
      send_req(v.off, v.len);
      ready_i = 1'b1;
      @(posedge clk); #1;
      v_i = 1'b0;
      for (int c = 0; c < v.nb + 3; c++) begin
         @(negedge clk);
         if (c == 0) chk("vec_latency", 32'(v_o), 32'd1);
         if (v_o) begin
            em = (got == 0) ? v.m_first : ((got == v.nb - 1) ? v.m_last : v.m_mid);
            chk("vec_mask", 32'(mask_o), 32'(em));
            chk("vec_mask_rev", 32'(mask_r), 32'(rev(em)));
            chk("vec_first", 32'(first_o), 32'(got == 0));
            chk("vec_last", 32'(last_o), 32'(got == v.nb - 1));
            got++;
         end
      end
      chk("vec_beats", 32'(got), 32'(v.nb));
   endtask

   task automatic chk_beat(input string name, input logic [W-1:0] m, input bit f, input bit l);
      chk({name, "_v"}, 32'(v_o), 32'd1);
      chk({name, "_mask"}, 32'(mask_o), 32'(m));
      chk({name, "_first"}, 32'(first_o), 32'(f));
      chk({name, "_last"}, 32'(last_o), 32'(l));
   endtask

   initial begin
      vecs[0] = '{3, 2, 1, 8'h18, 8'hFF, 8'h18};
      vecs[1] = '{5, 12, 3, 8'hE0, 8'hFF, 8'h01};
      vecs[2] = '{0, 16, 2, 8'hFF, 8'hFF, 8'hFF};
      vecs[3] = '{0, 8, 1, 8'hFF, 8'hFF, 8'hFF};
      vecs[4] = '{7, 1, 1, 8'h80, 8'hFF, 8'h80};
      vecs[5] = '{7, 2, 2, 8'h80, 8'hFF, 8'h01};
      vecs[6] = '{2, 3, 1, 8'h1C, 8'hFF, 8'h1C};
      vecs[7] = '{6, 10, 2, 8'hC0, 8'hFF, 8'hFF};
      vecs[8] = '{1, 23, 3, 8'hFE, 8'hFF, 8'hFF};
      vecs[9] = '{7, 4095, 513, 8'h80, 8'hFF, 8'h3F};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_v_o", 32'(v_o), 32'd0);
      chk("rst_mask", 32'(mask_o), 32'd0);
      chk("rst_first", 32'(first_o), 32'd0);
      chk("rst_last", 32'(last_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_state", 32'(state_o), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      foreach (vecs[i]) apply_vec(vecs[i]);

      // stall: ready_i 1,0,0,1 across a two-beat burst
      @(posedge clk); #1;
      send_req(0, 16);
      ready_i = 1'b1;
      @(posedge clk); #1;
      v_i = 1'b0;
      @(negedge clk);
      chk_beat("stall_b0", 8'hFF, 1'b1, 1'b0);
      chk("stall_state", 32'(state_o), 32'd1);
      @(posedge clk); #1;
      ready_i = 1'b0;
      @(negedge clk);
      chk_beat("stall_b1", 8'hFF, 1'b0, 1'b1);
      chk("stall_ready_lo", 32'(ready_o), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_beat("stall_hold", 8'hFF, 1'b0, 1'b1);
      @(posedge clk); #1;
      ready_i = 1'b1;
      @(negedge clk);
      chk_beat("stall_hold2", 8'hFF, 1'b0, 1'b1);
      chk("stall_ready_hi", 32'(ready_o), 32'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("stall_done", 32'(v_o), 32'd0);

      // back-to-back: second request offered during the last beat
      @(posedge clk); #1;
      send_req(5, 12);
      @(posedge clk); #1;
      v_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      send_req(2, 3);
      @(negedge clk);
      chk_beat("b2b_last", 8'h01, 1'b0, 1'b1);
      chk("b2b_ready", 32'(ready_o), 32'd1);
      @(posedge clk); #1;
      v_i = 1'b0;
      @(negedge clk);
      chk_beat("b2b_next", 8'h1C, 1'b1, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("b2b_done", 32'(v_o), 32'd0);

      // zero-length request is consumed with no beat
      @(posedge clk); #1;
      send_req(4, 0);
      @(negedge clk);
      chk("len0_ready", 32'(ready_o), 32'd1);
      @(posedge clk); #1;
      v_i = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("len0_no_beat", 32'(v_o), 32'd0);
      end

      // asynchronous reset in the middle of a burst
      @(posedge clk); #1;
      send_req(0, 40);
      @(posedge clk); #1;
      v_i = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_v_o", 32'(v_o), 32'd0);
      chk("arst_mask", 32'(mask_o), 32'd0);
      chk("arst_first", 32'(first_o), 32'd0);
      chk("arst_last", 32'(last_o), 32'd0);
      chk("arst_v_o_rev", 32'(v_o_r), 32'd0);
      #3 reset_n = 1'b1;
      chk("arst_ready", 32'(ready_o), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("arst_no_resume", 32'(v_o), 32'd0);
      end
      apply_vec(vecs[1]);

      // random traffic, inputs not held stable
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         v_i      = ($urandom_range(0, 99) < 40);
         offset_i = OW'($urandom_range(0, W - 1));
         if ($urandom_range(0, 9) == 0) len_i = '0;
         else if ($urandom_range(0, 19) == 0) len_i = LW'($urandom_range(1, 300));
         else len_i = LW'($urandom_range(1, 30));
         ready_i  = ($urandom_range(0, 99) < 70);
      end
      @(posedge clk); #1;
      v_i     = 1'b0;
      ready_i = 1'b1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'd0);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
